// File: rtl/mcu_bus_slave_pkg.sv
// Shared command codes and FSM state encodings for the MCU bus slave.
package mcu_bus_slave_pkg;

    localparam logic [7:0] CMD_GET_ID      = 8'h01;
    localparam logic [7:0] CMD_SET_ADDRESS = 8'h02;
    localparam logic [7:0] CMD_READ_STREAM = 8'h04;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SEND_ID = 2'd1;
    localparam logic [1:0] ST_ADDR    = 2'd2;
    localparam logic [1:0] ST_READ    = 2'd3;

endpackage

// File: rtl/mcu_bus_slave_busclk_sync.sv
// Synchroniser chain for the asynchronous MCU strobe plus a rising-edge detector.
module busclk_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic sysclk,
    input  logic reset,
    input  logic busclk,
    output logic beat
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], busclk};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign beat = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/mcu_bus_slave.sv
// MCU parallel-bus slave: decodes command/data beats, keeps the address register
// and drives registered streamed write / read-request strobes toward the core.
module mcu_bus_slave
    import mcu_bus_slave_pkg::*;
#(
    parameter int unsigned BUS_W       = 8,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          AUTO_INC    = 1'b1,
    parameter logic [7:0]  DEVICE_ID   = 8'hAE
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              busclk,
    input  logic [BUS_W-1:0]  bus_in,
    input  logic              command_data,
    output logic [BUS_W-1:0]  bus_out,
    output logic              wr_valid,
    output logic [BUS_W-1:0]  wr_data,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [BUS_W-1:0]  rd_data,
    input  logic              rd_valid,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic [ADDR_W-1:0] address,
    output logic              rd_overrun,
    output logic              led
);

    localparam int unsigned ADDR_BEATS = ADDR_W / BUS_W;
    localparam int unsigned CNT_W      = $clog2(ADDR_BEATS) + 1;

    logic beat;

    busclk_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .sysclk(sysclk),
        .reset (reset),
        .busclk(busclk),
        .beat  (beat)
    );

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] shadow_q, shadow_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic [BUS_W-1:0]  bus_out_q, bus_out_d;
    logic              wr_valid_q, wr_valid_d;
    logic [BUS_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              rd_req_q, rd_req_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic [7:0]        cmd_code_q, cmd_code_d;
    logic              led_q, led_d;
    logic              decode;
    logic [ADDR_W-1:0] next_addr;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shadow_d    = shadow_q;
        address_d   = address_q;
        bus_out_d   = bus_out_q;
        wr_valid_d  = 1'b0;
        wr_data_d   = wr_data_q;
        wr_addr_d   = wr_addr_q;
        rd_req_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        cmd_valid_d = 1'b0;
        cmd_code_d  = cmd_code_q;
        decode      = 1'b0;
        next_addr   = AUTO_INC ? address_q + ADDR_W'(1) : address_q;

        if (rd_valid) begin
            bus_out_d = rd_data;
            pending_d = 1'b0;
        end

        if (beat) begin
            case (state_q)
                ST_IDLE: begin
                    if (command_data) begin
                        wr_valid_d = 1'b1;
                        wr_data_d  = bus_in;
                        wr_addr_d  = address_q;
                        address_d  = next_addr;
                    end else begin
                        decode = 1'b1;
                    end
                end
                ST_SEND_ID: begin
                    bus_out_d   = BUS_W'(DEVICE_ID);
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = CMD_GET_ID;
                    state_d     = ST_IDLE;
                end
                ST_ADDR: begin
                    if (command_data) begin
                        shadow_d = (shadow_q << BUS_W) | ADDR_W'(bus_in);
                        if (cnt_q == CNT_W'(ADDR_BEATS - 1)) begin
                            address_d   = shadow_d;
                            cmd_valid_d = 1'b1;
                            cmd_code_d  = CMD_SET_ADDRESS;
                            state_d     = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        decode = 1'b1;
                    end
                end
                ST_READ: begin
                    if (command_data) begin
                        // rd_valid in the same cycle as the beat satisfies the outstanding request
                        if (pending_q && !rd_valid) begin
                            overrun_d = 1'b1;
                        end
                        address_d = next_addr;
                        rd_req_d  = 1'b1;
                        rd_addr_d = next_addr;
                        pending_d = 1'b1;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = CMD_READ_STREAM;
                        decode      = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (decode) begin
            state_d = ST_IDLE;
            case (bus_in[7:0])
                CMD_GET_ID: state_d = ST_SEND_ID;
                CMD_SET_ADDRESS: begin
                    cnt_d   = '0;
                    state_d = ST_ADDR;
                end
                CMD_READ_STREAM: begin
                    rd_req_d  = 1'b1;
                    rd_addr_d = address_q;
                    pending_d = 1'b1;
                    state_d   = ST_READ;
                end
                default: ;
            endcase
        end

        led_d = led_q ^ cmd_valid_d;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            shadow_q    <= '0;
            address_q   <= '0;
            bus_out_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_data_q   <= '0;
            wr_addr_q   <= '0;
            rd_req_q    <= 1'b0;
            rd_addr_q   <= '0;
            pending_q   <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= '0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shadow_q    <= shadow_d;
            address_q   <= address_d;
            bus_out_q   <= bus_out_d;
            wr_valid_q  <= wr_valid_d;
            wr_data_q   <= wr_data_d;
            wr_addr_q   <= wr_addr_d;
            rd_req_q    <= rd_req_d;
            rd_addr_q   <= rd_addr_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            led_q       <= led_d;
        end
    end

    assign bus_out    = bus_out_q;
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign wr_addr    = wr_addr_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_code   = cmd_code_q;
    assign address    = address_q;
    assign rd_overrun = overrun_q;
    assign led        = led_q;

endmodule
